// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - multi-cycle data-memory access stage (word port, sub-word stores by read-modify-write)
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   start, is_store, ctr   request strobe (accepted in IDLE only), direction, access type
//   addr, wdata            byte address and store data, sampled with start
//   busy, done, err        in-progress flag, one-cycle completion pulse, error qualifier of done
//   rdata                  lane-aligned load result, zero-filled above the selected byte/half
//   mem_req, mem_we        memory request (held until mem_ack) and write qualifier
//   mem_addr, mem_wdata    word address and full write word
//   mem_ack, mem_rdata     memory completion strobe and read word

module dmem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  ctr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;

  state_t        state;
  state_t        state_nx;

  logic          st_q;
  logic [2:0]    ctr_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [CW-1:0] tcnt;

  logic          legal;
  logic          word_op;
  logic          half_op;
  logic          chk_err;
  logic          in_req;
  logic          tmo;

  // Move the addressed byte/half down to bit 0 and zero the rest.
  function automatic logic [31:0] lane_load(input logic [2:0] c, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (c)
      3'b001, 3'b010: lane_load = {24'h0, b};
      3'b011, 3'b100: lane_load = {16'h0, h};
      default:        lane_load = w;
    endcase
  endfunction

  // Insert the store byte/half into the word just read back.
  function automatic logic [31:0] lane_merge(input logic [2:0] c, input logic [1:0] off,
                                             input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (c)
      3'b001:  r[{off, 3'b000} +: 8]     = d[7:0];
      3'b011:  r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    lane_merge = r;
  endfunction

  always_comb begin
    legal = 1'b0;
    if (st_q) begin
      legal = (ctr_q == 3'b000) || (ctr_q == 3'b001) || (ctr_q == 3'b011);
    end else begin
      legal = (ctr_q <= 3'b100);
    end
    word_op = (ctr_q == 3'b000);
    half_op = (ctr_q == 3'b011) || (ctr_q == 3'b100);
    chk_err = !legal || (word_op && (off_q != 2'b00)) || (half_op && off_q[0]);
  end

  assign in_req = (state == RD) || (state == WR);
  // Last allowed unacknowledged cycle: the counter would reach TIMEOUT_CYC.
  assign tmo    = in_req && !mem_ack && (tcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: begin
        if (chk_err) begin
          state_nx = FIN;
        end else if (st_q && word_op) begin
          state_nx = WR;
        end else begin
          state_nx = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          state_nx = st_q ? WR : FIN;
        end else if (tmo) begin
          state_nx = FIN;
        end
      end
      WR:    if (mem_ack || tmo) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      CHECK: busy = 1'b1;
      RD: begin
        busy    = 1'b1;
        mem_req = 1'b1;
      end
      WR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      FIN: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= 1'b0;
      ctr_q     <= 3'b000;
      off_q     <= 2'b00;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      tcnt      <= '0;
      rdata     <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      // Counter runs only across unacknowledged request cycles, so it is
      // zero on every entry to RD or WR.
      if (in_req && !mem_ack) begin
        tcnt <= tcnt + CW'(1);
      end else begin
        tcnt <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            st_q     <= is_store;
            ctr_q    <= ctr;
            off_q    <= addr[1:0];
            wdata_q  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            rdata    <= 32'h0;
            err_q    <= 1'b0;
          end
        end
        CHECK: begin
          if (chk_err) err_q <= 1'b1;
          mem_wdata <= wdata_q;
        end
        RD: begin
          if (mem_ack) begin
            if (st_q) begin
              mem_wdata <= lane_merge(ctr_q, off_q, mem_rdata, wdata_q);
            end else begin
              rdata <= lane_load(ctr_q, off_q, mem_rdata);
            end
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        WR: begin
          if (tmo) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed self-checking bench for dmem_access_unit

module tb_dmem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  ctr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .ctr       (ctr),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Memory model: decides ack on the falling edge for the next rising edge.
  logic [31:0] mem [0:1023];
  bit          mem_init  = 1'b0;
  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          ack_wait  = 0;
  bit          ack_en    = 1'b1;
  int          wcnt      = 0;
  int          rd_cnt    = 0;
  int          wr_cnt    = 0;
  int          req_cyc   = 0;
  int          we_cyc    = 0;
  logic [31:0] last_wr   = 32'h0;

  assign mem_ack = model_ack | force_ack;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h040] = 32'h8899AABC;
      mem[10'h080] = 32'h11223344;
      mem[10'h0C0] = 32'hDEADBE77;
      mem_init = 1'b1;
    end
    model_ack = 1'b0;
    if (mem_req) begin
      req_cyc++;
      if (mem_we) we_cyc++;
      if (ack_en && wcnt >= ack_wait) begin
        model_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          wr_cnt++;
          last_wr = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr[11:2]];
          rd_cnt++;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; lat counts cycles from the start cycle (cycle 0) to done.
  task automatic run_op(input logic st, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input bit poke, output int lat,
                        output logic e, output logic [31:0] rd, output logic bz,
                        output logic d2);
    int cyc;
    @(negedge clk);
    is_store = st;
    ctr      = c;
    addr     = a;
    wdata    = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke) start = (cyc == 3);
    end
    lat   = done ? cyc : -1;
    e     = err;
    rd    = rdata;
    bz    = busy;
    start = 1'b0;
    @(posedge clk);
    #1;
    d2 = done;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  c;
    logic [31:0] a;
    int          lat;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t        vt [0:12];
  int          lat;
  logic        e;
  logic [31:0] rd;
  logic        bz;
  logic        d2;
  int          req0;
  int          rd0;
  int          wr0;
  int          we0;
  int          k;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    is_store = 1'b0;
    ctr      = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Zero-wait loads from 0x8899AABC at 0x100, then checks that never touch memory.
    vt[0]  = '{1'b0, 3'b001, 32'h103, 3, 1'b0, 32'h00000088};
    vt[1]  = '{1'b0, 3'b011, 32'h102, 3, 1'b0, 32'h00008899};
    vt[2]  = '{1'b0, 3'b000, 32'h100, 3, 1'b0, 32'h8899AABC};
    vt[3]  = '{1'b0, 3'b010, 32'h101, 3, 1'b0, 32'h000000AA};
    vt[4]  = '{1'b0, 3'b100, 32'h100, 3, 1'b0, 32'h0000AABC};
    vt[5]  = '{1'b0, 3'b001, 32'h100, 3, 1'b0, 32'h000000BC};
    vt[6]  = '{1'b0, 3'b011, 32'h101, 2, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 3'b000, 32'h102, 2, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 3'b010, 32'h200, 2, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 3'b000, 32'h103, 2, 1'b1, 32'h0};
    vt[10] = '{1'b0, 3'b101, 32'h100, 2, 1'b1, 32'h0};
    vt[11] = '{1'b1, 3'b011, 32'h203, 2, 1'b1, 32'h0};
    vt[12] = '{1'b1, 3'b100, 32'h200, 2, 1'b1, 32'h0};

    for (int i = 0; i <= 12; i++) begin
      req0 = req_cyc;
      run_op(vt[i].st, vt[i].c, vt[i].a, 32'h0, 1'b0, lat, e, rd, bz, d2);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_err", i), e, vt[i].e);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_busy_fin", i), bz, 1'b0);
      chk($sformatf("v%0d_done_pulse", i), d2, 1'b0);
      if (vt[i].e) chk($sformatf("v%0d_noreq", i), 32'(req_cyc - req0), 32'd0);
      if (i == 2) chk("v2_maddr", mem_addr, 32'h100);
    end

    // Sub-word stores as read-modify-write, then a plain sw.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_op(1'b1, 3'b001, 32'h201, 32'h000000EE, 1'b0, lat, e, rd, bz, d2);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_err", e, 1'b0);
    chk("sb_reads", 32'(rd_cnt - rd0), 32'd1);
    chk("sb_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("sb_wdata", last_wr, 32'h1122EE44);

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_op(1'b1, 3'b011, 32'h202, 32'h0000BEEF, 1'b0, lat, e, rd, bz, d2);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("sh_wdata", last_wr, 32'hBEEFEE44);

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_op(1'b1, 3'b000, 32'h204, 32'hCAFEF00D, 1'b0, lat, e, rd, bz, d2);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("sw_wdata", last_wr, 32'hCAFEF00D);
    chk("sw_mem", mem[10'h081], 32'hCAFEF00D);

    // Five wait cycles with a start pulsed during the read.
    ack_wait = 5;
    req0 = req_cyc;
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 1'b1, lat, e, rd, bz, d2);
    chk("wait_lat", 32'(lat), 32'd8);
    chk("wait_err", e, 1'b0);
    chk("wait_rdata", rd, 32'h00000077);
    chk("wait_reqcyc", 32'(req_cyc - req0), 32'd6);
    @(posedge clk);
    #1;
    chk("wait_idle", busy, 1'b0);
    chk("wait_noreq", 32'(req_cyc - req0), 32'd6);
    ack_wait = 0;

    // No acknowledge: timeout on a load and on a sub-word store.
    ack_en = 1'b0;
    req0 = req_cyc;
    run_op(1'b0, 3'b000, 32'h100, 32'h0, 1'b0, lat, e, rd, bz, d2);
    chk("tmo_lat", 32'(lat), 32'd10);
    chk("tmo_err", e, 1'b1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_reqcyc", 32'(req_cyc - req0), 32'd8);

    req0 = req_cyc;
    we0  = we_cyc;
    run_op(1'b1, 3'b001, 32'h201, 32'h00000055, 1'b0, lat, e, rd, bz, d2);
    chk("tmo_sb_lat", 32'(lat), 32'd10);
    chk("tmo_sb_err", e, 1'b1);
    chk("tmo_sb_reqcyc", 32'(req_cyc - req0), 32'd8);
    chk("tmo_sb_nowrite", 32'(we_cyc - we0), 32'd0);

    // Reset while waiting in WR.
    @(negedge clk);
    is_store = 1'b1;
    ctr      = 3'b000;
    addr     = 32'h100;
    wdata    = 32'h12345678;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!mem_we && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rwr_reach_wr", mem_we, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rwr_busy", busy, 1'b0);
    chk("rwr_done", done, 1'b0);
    chk("rwr_err", err, 1'b0);
    chk("rwr_rdata", rdata, 32'h0);
    chk("rwr_req", mem_req, 1'b0);
    chk("rwr_we", mem_we, 1'b0);
    chk("rwr_maddr", mem_addr, 32'h0);
    chk("rwr_mwdata", mem_wdata, 32'h0);
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_done", done, 1'b0);
    chk("late_ack_mem", mem[10'h040], 32'h8899AABC);

    ack_en = 1'b1;
    run_op(1'b0, 3'b000, 32'h200, 32'h0, 1'b0, lat, e, rd, bz, d2);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_err", e, 1'b0);
    chk("post_rst_rdata", rd, 32'hBEEFEE44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
